uart_tx_arb: RTL and testbench

Round-robin, packet-locking arbiter that shares one `uart_tx` transmitter among `NUM_REQ` byte-stream requesters, such as the CPU MMIO path, the debug monitor and the boot loader. It accepts bytes over per-requester valid/ready handshakes and buffers them in an internal TX FIFO. The FIFO's read port matches the `uart_tx` FIFO interface exactly. A granted requester keeps ownership until it sends a byte flagged `last`, so multi-byte messages never interleave on the serial line.

---
 rtl/uart_tx_arb.sv | 129 ++++++++++++
 tb/tb_uart_tx_arb.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Round-robin, packet-locking arbiter feeding a shared uart_tx TX FIFO.
// Optional idle-lock watchdog is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arb #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [8*NUM_REQ-1:0]          req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          fifo_rd_en,
  output logic [7:0]                    fifo_data_out,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id_o,
  output logic                          busy_o
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

  arb_state_e    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d, rr_q, rr_d, grant_inc, pick_id;
  logic          pick_vld;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [7:0]    sel_data, dout_q;
  logic          full, empty, accept, pop, owner_vld, owner_last, release_lock;
  int            idx;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop   = fifo_rd_en && !empty;

  assign owner_vld  = req_valid_i[grant_q];
  assign owner_last = req_last_i[grant_q];
  assign sel_data   = req_data_i[8*int'(grant_q) +: 8];
  assign accept     = (state_q == ARB_LOCKED) && owner_vld && !full;
  assign grant_inc  = (grant_q == GW'(NUM_REQ-1)) ? '0 : grant_q + GW'(1);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rdy
    assign req_ready_o[i] = (state_q == ARB_LOCKED) && (grant_q == GW'(i)) && !full;
  end

  // Descending scan so the lowest offset from rr_q wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    idx      = 0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid_i[idx]) begin
        pick_vld = 1'b1;
        pick_id  = GW'(idx);
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  logic [TW-1:0] wd_cnt;
  logic          wd_fire;

  assign wd_fire = (state_q == ARB_LOCKED) && !owner_vld && (wd_cnt == TW'(TIMEOUT-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                wd_cnt <= '0;
    else if (state_q != ARB_LOCKED || accept)  wd_cnt <= '0;
    else if (!owner_vld)                       wd_cnt <= wd_cnt + TW'(1);
  end

  assign release_lock = (accept && owner_last) || wd_fire;
`else
  assign release_lock = accept && owner_last;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    case (state_q)
      ARB_IDLE: if (pick_vld) begin
        state_d = ARB_LOCKED;
        grant_d = pick_id;
      end
      ARB_LOCKED: if (release_lock) begin
        state_d = ARB_IDLE;
        rr_d    = grant_inc;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      dout_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      if (accept) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
        dout_q <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  // Storage is not reset; pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= sel_data;
  end

  assign fifo_data_out = dout_q;
  assign fifo_empty    = empty;
  assign fifo_count_o  = wr_ptr - rd_ptr;
  assign grant_id_o    = grant_q;
  assign busy_o        = (state_q == ARB_LOCKED);
endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: per-requester byte queues drive the
// handshakes, a monitor checks popped bytes against hand-ordered expectations.
module tb_uart_tx_arb;
  localparam int NR = 4;
  localparam int FD = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_valid_i;
  logic [8*NR-1:0]   req_data_i;
  logic [NR-1:0]     req_last_i;
  logic [NR-1:0]     req_ready_o;
  logic              fifo_rd_en;
  logic [7:0]        fifo_data_out;
  logic              fifo_empty;
  logic [4:0]        fifo_count_o;
  logic [1:0]        grant_id_o;
  logic              busy_o;

  uart_tx_arb #(.NUM_REQ(NR), .FIFO_DEPTH(FD), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_ready_o(req_ready_o), .fifo_rd_en(fifo_rd_en), .fifo_data_out(fifo_data_out),
    .fifo_empty(fifo_empty), .fifo_count_o(fifo_count_o), .grant_id_o(grant_id_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q [$];
  logic [8:0] txq [NR][$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int r, input logic [7:0] d, input logic l);
    txq[r].push_back({l, d});
  endtask

  task automatic pop1();
    fifo_rd_en = 1'b1;
    step();
    fifo_rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int r = 0; r < NR; r++) txq[r].delete();
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_cnt(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (int'(fifo_count_o) != target && n < budget) begin
      step();
      n++;
    end
    chk(name, 32'(fifo_count_o), 32'(target));
  endtask

  // Requester driver: retire a queue head once its handshake has fired.
  initial begin
    logic [NR-1:0] acc;
    req_valid_i = '0;
    req_data_i  = '0;
    req_last_i  = '0;
    forever begin
      @(posedge clk);
      acc = req_valid_i & req_ready_o;
      #1;
      for (int r = 0; r < NR; r++) begin
        if (acc[r] && txq[r].size() > 0) void'(txq[r].pop_front());
        if (txq[r].size() > 0) begin
          req_valid_i[r]         = 1'b1;
          req_last_i[r]          = txq[r][0][8];
          req_data_i[8*r +: 8]   = txq[r][0][7:0];
        end else begin
          req_valid_i[r]         = 1'b0;
          req_last_i[r]          = 1'b0;
          req_data_i[8*r +: 8]   = 8'h00;
        end
      end
    end
  end

  // Monitor: every real pop yields the next expected byte one clock later.
  initial begin
    logic popd;
    forever begin
      @(posedge clk);
      popd = fifo_rd_en && !fifo_empty && rst_n;
      #1;
      if (popd) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL pop_unexpected: got %0h expected no pop data", fifo_data_out);
        end else begin
          chk("pop_data", 32'(fifo_data_out), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    fifo_rd_en = 1'b0;
    repeat (3) step();
    chk("rst_ready", 32'(req_ready_o), 32'h0);
    chk("rst_data",  32'(fifo_data_out), 32'h0);
    chk("rst_empty", 32'(fifo_empty), 32'h1);
    chk("rst_count", 32'(fifo_count_o), 32'h0);
    chk("rst_grant", 32'(grant_id_o), 32'h0);
    chk("rst_busy",  32'(busy_o), 32'h0);
    rst_n = 1'b1;
    step();

    // Single message from requester 2
    send(2, 8'hA5, 1'b1); exp_q.push_back(8'hA5);
    step();
    chk("t1_ready_pre", 32'(req_ready_o), 32'h0);
    step();
    chk("t1_ready", 32'(req_ready_o), 32'h4);
    chk("t1_busy",  32'(busy_o), 32'h1);
    chk("t1_grant", 32'(grant_id_o), 32'h2);
    step();
    chk("t1_busy_off", 32'(busy_o), 32'h0);
    chk("t1_empty",    32'(fifo_empty), 32'h0);
    chk("t1_count",    32'(fifo_count_o), 32'h1);
    pop1();
    step();
    chk("t1_empty_after", 32'(fifo_empty), 32'h1);

    // Round-robin: 0, 1, 3, then 0 again
    do_reset();
    send(0, 8'h10, 1'b1); send(0, 8'h11, 1'b1); send(1, 8'h20, 1'b1); send(3, 8'h30, 1'b1);
    exp_q.push_back(8'h10); exp_q.push_back(8'h20); exp_q.push_back(8'h30); exp_q.push_back(8'h11);
    wait_cnt("t2_count", 4, 60);
    repeat (4) pop1();
    step();
    chk("t2_empty", 32'(fifo_empty), 32'h1);

    // Message lock: requester 0's three bytes before requester 1
    do_reset();
    send(0, 8'h11, 1'b0); send(0, 8'h22, 1'b0); send(0, 8'h33, 1'b1); send(1, 8'h44, 1'b1);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    step(); step();
    chk("t3_ready0", 32'(req_ready_o), 32'h1);
    chk("t3_grant_a", 32'(grant_id_o), 32'h0);
    step();
    chk("t3_grant_b", 32'(grant_id_o), 32'h0);
    step();
    chk("t3_grant_c", 32'(grant_id_o), 32'h0);
    chk("t3_busy_c",  32'(busy_o), 32'h1);
    step();
    chk("t3_idle",  32'(busy_o), 32'h0);
    chk("t3_count", 32'(fifo_count_o), 32'h3);
    step();
    chk("t3_grant_next", 32'(grant_id_o), 32'h1);
    wait_cnt("t3_count_all", 4, 60);
    repeat (4) pop1();

    // FIFO boundaries: 17-byte message against a 16-entry FIFO
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send(0, 8'(8'h40 + i), (i == 16));
      exp_q.push_back(8'(8'h40 + i));
    end
    wait_cnt("t4_full_count", 16, 60);
    chk("t4_full_ready", 32'(req_ready_o), 32'h0);
    step();
    chk("t4_full_hold", 32'(fifo_count_o), 32'd16);
    chk("t4_full_busy", 32'(busy_o), 32'h1);
    pop1();
    chk("t4_ready_back", 32'(req_ready_o), 32'h1);
    chk("t4_count_15",   32'(fifo_count_o), 32'd15);
    step();
    chk("t4_refill", 32'(fifo_count_o), 32'd16);
    chk("t4_done",   32'(busy_o), 32'h0);
    fifo_rd_en = 1'b1;
    repeat (16) step();
    fifo_rd_en = 1'b0;
    chk("t4_drained_empty", 32'(fifo_empty), 32'h1);
    chk("t4_drained_count", 32'(fifo_count_o), 32'h0);
    pop1();
    step();
    chk("t4_extra_pop_data",  32'(fifo_data_out), 32'h50);
    chk("t4_extra_pop_empty", 32'(fifo_empty), 32'h1);

`ifdef UART_ARB_TIMEOUT_EN
    // Watchdog releases an abandoned lock after 8 idle cycles
    do_reset();
    send(1, 8'h61, 1'b0); send(2, 8'h62, 1'b1);
    exp_q.push_back(8'h61); exp_q.push_back(8'h62);
    step(); step();
    chk("t5_grant1", 32'(grant_id_o), 32'h1);
    step();
    chk("t5_busy_after_beat", 32'(busy_o), 32'h1);
    repeat (7) step();
    chk("t5_busy_last", 32'(busy_o), 32'h1);
    step();
    chk("t5_released", 32'(busy_o), 32'h0);
    step();
    chk("t5_grant2", 32'(grant_id_o), 32'h2);
    chk("t5_busy2",  32'(busy_o), 32'h1);
    wait_cnt("t5_count", 2, 60);
    repeat (2) pop1();
`endif

    // Asynchronous reset during requester 0's second byte
    do_reset();
    send(0, 8'h71, 1'b0); send(0, 8'h72, 1'b0); send(0, 8'h73, 1'b1);
    step(); step(); step();
    rst_n = 1'b0;
    for (int r = 0; r < NR; r++) txq[r].delete();
    #1;
    chk("t6_ready", 32'(req_ready_o), 32'h0);
    chk("t6_empty", 32'(fifo_empty), 32'h1);
    chk("t6_count", 32'(fifo_count_o), 32'h0);
    chk("t6_grant", 32'(grant_id_o), 32'h0);
    chk("t6_busy",  32'(busy_o), 32'h0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("t6_empty_after", 32'(fifo_empty), 32'h1);
    send(3, 8'h83, 1'b1); send(0, 8'h80, 1'b1);
    exp_q.push_back(8'h80); exp_q.push_back(8'h83);
    step(); step();
    chk("t6_grant0", 32'(grant_id_o), 32'h0);
    chk("t6_busy0",  32'(busy_o), 32'h1);
    wait_cnt("t6_count2", 2, 60);
    repeat (2) pop1();
    step(); step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
